// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/synchronizer slice.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CNT_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CNT_LO  = 2'b11
  } db_state_t;

  localparam int DB_SYNC_STAGES_DEF = 2;
  localparam int DB_STABLE_CNT_DEF  = 50000;

endpackage

// File: rtl/debounce_sync_chain.sv
// Parameterized multi-flop synchronizer with asynchronous active-low reset to 0.
// Reusable for any asynchronous input bus; DEPTH must be at least 2.
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage <= '0;
    else      stage <= {stage[DEPTH-2:0], d};
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw asynchronous level into a clean registered level.
// Optional rise/fall strobes are built only when DEBOUNCE_EDGE_STROBE_EN is defined.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DB_SYNC_STAGES_DEF,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = DB_STABLE_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             din_s;
  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  sync_chain #(
    .WIDTH (1),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE_LO: if (din_s) begin
        if (STABLE_CNT == 1) state_nxt = IDLE_HI;
        else begin
          state_nxt = CNT_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CNT_HI: begin
        if (!din_s) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CNT_ONE;
      end
      IDLE_HI: if (!din_s) begin
        if (STABLE_CNT == 1) state_nxt = IDLE_LO;
        else begin
          state_nxt = CNT_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CNT_LO: begin
        if (din_s) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CNT_ONE;
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode only the state register, so nothing reaches them combinationally from din.
  always_comb begin
    dout = (state == IDLE_HI) || (state == CNT_LO);
    busy = (state == CNT_HI)  || (state == CNT_LO);
  end

`ifdef DEBOUNCE_EDGE_STROBE_EN
  logic dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= 1'b0;
    else      dout_q <= dout;
  end

  assign rise = dout & ~dout_q;
  assign fall = ~dout & dout_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus random bouncing input
// compared against a run-length reference model. Honours DEBOUNCE_EDGE_STROBE_EN.
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_STROBE_EN
  localparam bit STROBE_EN = 1'b1;
`else
  localparam bit STROBE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout, busy, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: din delay line, dout and length of the current disagreement run.
  logic q_din[$];
  logic m_dout, m_busy, m_rise, m_fall;
  int   m_run;

  debounce_sync #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (16),
    .STABLE_CNT  (STABLE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q_din.delete();
    for (int i = 0; i < SYNC; i++) q_din.push_front(1'b0);
    m_dout = 1'b0;
    m_busy = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  endfunction

  // dout flips once STABLE consecutive synchronized samples have disagreed with it.
  function automatic void model_edge();
    logic ds, prev;
    if (!rst) begin
      model_reset();
      return;
    end
    ds = q_din.pop_back();
    q_din.push_front(din);
    prev = m_dout;
    if (ds != m_dout) m_run++;
    else              m_run = 0;
    if (m_run == STABLE) begin
      m_dout = ~m_dout;
      m_run  = 0;
    end
    m_busy = (m_run > 0);
    m_rise = STROBE_EN && m_dout && !prev;
    m_fall = STROBE_EN && !m_dout && prev;
  endfunction

  task automatic compare_all();
    check("dout", dout, m_dout);
    check("busy", busy, m_busy);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
  endtask

  // One clock: model and DUT advance on the rising edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  int first_hi;
  int busy_cnt;
  int seg_len;

  initial begin
    rst = 1'b0;
    din = 1'b1;
    model_reset();
    #1;
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    step();
    step();

    // Release with din high: dout rises at the sixth edge.
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rel_dout", dout, (k >= 6));
    end

    // Clean fall.
    din = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("fall_busy", busy, (k >= 3 && k < 6));
      check("fall_dout", dout, (k < 6));
      check("fall_strobe", fall, (STROBE_EN && k == 6));
      check("fall_rise0", rise, 0);
    end
    step();
    check("fall_strobe_1cyc", fall, 0);

    // Clean rise.
    din = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rise_busy", busy, (k >= 3 && k < 6));
      check("rise_dout", dout, (k >= 6));
      check("rise_strobe", rise, (STROBE_EN && k == 6));
    end
    step();
    check("rise_strobe_1cyc", rise, 0);

    // Back to low, then a bounce: high 3, low 1, high again.
    din = 1'b0;
    for (int k = 0; k < 8; k++) step();
    first_hi = 0;
    for (int k = 1; k <= 14; k++) begin
      din = (k == 4) ? 1'b0 : 1'b1;
      step();
      if (k == 6) check("bounce_busy_drop", busy, 0);
      if (dout && first_hi == 0) first_hi = k;
    end
    check("bounce_first_hi", first_hi, 10);

    // Single-cycle glitch on a stable low.
    din = 1'b0;
    for (int k = 0; k < 8; k++) step();
    busy_cnt = 0;
    first_hi = 0;
    for (int k = 1; k <= 8; k++) begin
      din = (k == 1);
      step();
      if (busy) busy_cnt++;
      if (dout || rise) first_hi = k;
    end
    check("glitch_busy_le1", (busy_cnt <= 1), 1);
    check("glitch_no_change", first_hi, 0);

    // Reset during qualification with cnt at 2.
    din = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    check("midq_busy", busy, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("midq_rst_dout", dout, 0);
    check("midq_rst_busy", busy, 0);
    step();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("midq_rel_dout", dout, (k >= 6));
    end

    // Random bouncing input with occasional resets.
    for (int s = 0; s < 60; s++) begin
      din = 1'($urandom_range(0, 1));
      seg_len = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        rst = 1'b1;
      end
      for (int k = 0; k < seg_len; k++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that sits directly upstream of the async-reset D register: takes a raw, asynchronous, bouncing level (push-button or switch), synchronizes it into the `clk` domain, and filters out glitches. The result is a clean, registered level `dout` that is safe to drive the register's `D` input. It optionally also produces single-cycle rise/fall strobes.

## Interface
- `SYNC_STAGES`, 2 — number of synchronizer flops; legal range 2..4.
- `CNT_W`, 16 — stability counter width.
- `STABLE_CNT`, 50000 — consecutive cycles the synchronized input must differ from `dout` before `dout` changes; legal range 1 .. 2^CNT_W−1.

- `clk`  input  1  — single clock; all state updates on rising edge.
- `rst`  input  1  — asynchronous, active-low reset; asserts immediately, releases on the next `clk` edge.
- `din`  input  1  — raw asynchronous level.
- `dout`  output  1  — debounced, registered level.
- `busy`  output  1  — high while a candidate transition is being qualified.
- `rise`  output  1  — one-cycle strobe on a 0→1 change of `dout`.
- `fall`  output  1  — one-cycle strobe on a 1→0 change of `dout`.

## Operation
- **Synchronizer:** `din` passes through `SYNC_STAGES` flops. The last stage is `din_s`, the only internal consumer of `din`.
- **FSM states:** `IDLE_LO`, `CNT_HI`, `IDLE_HI`, `CNT_LO`.
  - `dout` = 1 in `IDLE_HI` and `CNT_LO`; `dout` = 0 otherwise.
  - `busy` = 1 in `CNT_HI` and `CNT_LO`.
- **From `IDLE_LO`:**
  - `din_s`=1 → go to `CNT_HI` with `cnt`←1.
  - If `STABLE_CNT`=1, go straight to `IDLE_HI` instead.
- **In `CNT_HI`:**
  - `din_s`=0 → back to `IDLE_LO`, `cnt`←0 (bounce rejected).
  - `din_s`=1 and `cnt`==STABLE_CNT−1 → go to `IDLE_HI`, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- **`IDLE_HI` / `CNT_LO`:** mirror images of the above with the polarity inverted.
- **Counter arithmetic:** `cnt` is unsigned `CNT_W` bits. It never wraps, because it is cleared on reaching STABLE_CNT−1.
- **Bounce during qualification:** any single-cycle disagreement restarts qualification from zero. There is no partial credit.
- **Reset values:**
  - synchronizer flops = 0
  - `cnt` = 0
  - state = `IDLE_LO`
  - `dout`, `busy`, `rise`, `fall` = 0
- **Reset mid-qualification:** the pending transition is discarded. If `din` is held high, a full qualification restarts after release.

## Timing
- **Latency:** `din` changes and is then stable (meeting setup before edge 1). `dout` changes after edge `SYNC_STAGES` + `STABLE_CNT`.
  - Example: 2 + 50000 cycles.
- **`busy`:** rises one edge after `din_s` first disagrees with `dout`.
  - It falls on the same edge that `dout` toggles.
  - It also falls on the edge the disagreement ends.
- **Outputs:** all outputs are registered. There is no combinational path from `din`.
- **Minimum gap between `dout` toggles:** `STABLE_CNT` cycles.
- **Reset release:** no transition is possible until `SYNC_STAGES` + `STABLE_CNT` edges after reset release.

## Configuration
- **Macro:** `DEBOUNCE_EDGE_STROBE_EN`.
- **Defined:**
  - `rise` pulses high for exactly one cycle, coincident with the first cycle of `dout`=1.
  - `fall` does the same for the first cycle of `dout`=0.
  - Both come from a registered previous-`dout` compare.
- **Undefined:**
  - `rise` and `fall` are tied to 0.
  - The edge-detect flop is not instantiated.
  - The ports remain present.

## Structure
- **Shared package `debounce_pkg`:**
  - state typedef `db_state_t` (2-bit, four encodings above)
  - default constants `DB_SYNC_STAGES_DEF`=2 and `DB_STABLE_CNT_DEF`=50000
- **Sub-module `sync_chain`:**
  - parameterized flop chain (width 1, depth `SYNC_STAGES`) with async active-low reset to 0
  - reusable for other asynchronous inputs
- **Top level:** holds the FSM, the counter and the optional strobe logic.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `STABLE_CNT`=4.
- **Reset:** hold `rst`=0 with `din`=1 → `dout`, `busy`, `rise`, `fall` all 0. Release reset → `dout`=1 at edge 6 after release.
- **Clean rise:** `din` 0→1 before edge 1 → `busy`=1 after edge 3, `dout`=1 after edge 6. With the macro defined, `rise`=1 for exactly that one cycle.
- **Bounce rejection:** `din` high for 3 cycles, low for 1, then high → no `dout` change until 4 consecutive high `din_s` samples. `cnt` restarts and `busy` drops for one cycle.
- **Glitch:** a 1-cycle `din` pulse on a stable 0 → `dout` stays 0 and `rise` stays 0. `busy` pulses for at most one cycle.
- **Reset mid-qualification:** assert `rst` during `CNT_HI` with `cnt`=2 → `dout`=0 and state `IDLE_LO` immediately. With `din` held at 1, `dout`=1 six edges after release.
- **Fall with macro undefined:** 1→0 qualification → `dout`=0 after 6 edges. `fall` and `rise` remain 0 throughout.
